// File: rtl/cu_pkg.sv
// Shared control-unit definitions: op-code encodings and the branch-condition helper.
package cu_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] JMP  = 4'd0;
    localparam logic [OP_W-1:0] BEQ  = 4'd1;
    localparam logic [OP_W-1:0] BNE  = 4'd2;
    localparam logic [OP_W-1:0] CALL = 4'd3;
    localparam logic [OP_W-1:0] RET  = 4'd4;
    localparam logic [OP_W-1:0] BLT  = 4'd5;
    localparam logic [OP_W-1:0] JR   = 4'd6;

    // Operand compares are done by the caller so this stays width-independent.
    function automatic logic branch_cond(input logic [OP_W-1:0] op,
                                         input logic            eq,
                                         input logic            lt);
        logic res;
        res = 1'b0;
        case (op)
            BEQ:     res = eq;
            BNE:     res = ~eq;
            BLT:     res = lt;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ret_addr_stack.sv
// Return-address LIFO; push-on-full and pop-on-empty are ignored, and the
// storage itself is never reset.
module ret_addr_stack #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DEPTH  = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [ADDR_W-1:0]        din,
    output logic [ADDR_W-1:0]        dout,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]  depth_q, depth_d;
    logic [PTR_W-1:0]  wr_idx, rd_idx;
    logic              do_push, do_pop;

    assign full    = (depth_q == CNT_W'(DEPTH));
    assign empty   = (depth_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign wr_idx  = depth_q[PTR_W-1:0];
    assign rd_idx  = depth_q[PTR_W-1:0] - PTR_W'(1);
    assign dout    = mem_q[rd_idx];
    assign depth   = depth_q;

    always_comb begin
        depth_d = depth_q;
        if (do_push) begin
            depth_d = depth_q + CNT_W'(1);
        end else if (do_pop) begin
            depth_d = depth_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with jump/branch/call/return sequencing and a
// hardware return-address stack with sticky overflow/underflow flags.
module pc_sequencer
    import cu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 19,
    parameter int unsigned       DATA_W   = 19,
    parameter int unsigned       DEPTH    = 256,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   op_valid,
    input  logic [OP_W-1:0]        ctrl_op,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      r1,
    input  logic [DATA_W-1:0]      r2,
    input  logic                   err_clr,
    output logic [ADDR_W-1:0]      pc,
    output logic                   taken,
    output logic [$clog2(DEPTH):0] depth,
    output logic                   stack_full,
    output logic                   stack_empty,
    output logic                   ovf_err,
    output logic                   udf_err
);

    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, tos;
    logic              taken_q, taken_d;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic              push, pop, ovf_set, udf_set;
    logic              ops_eq, ops_lt;

    assign pc_inc = pc_q + ADDR_W'(1);
    assign ops_eq = (r1 == r2);
    assign ops_lt = ($signed(r1) < $signed(r2));

    ret_addr_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (tos),
        .depth (depth),
        .full  (stack_full),
        .empty (stack_empty)
    );

    // Any redirect counts as taken, even when its target happens to equal pc+1.
    always_comb begin
        pc_d    = pc_q;
        taken_d = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        if (op_valid) begin
            pc_d = pc_inc;
            case (ctrl_op)
                JMP: begin
                    pc_d    = addr;
                    taken_d = 1'b1;
                end
                BEQ, BNE, BLT: begin
                    if (branch_cond(ctrl_op, ops_eq, ops_lt)) begin
                        pc_d    = addr;
                        taken_d = 1'b1;
                    end
                end
                CALL: begin
                    if (stack_full) begin
                        ovf_set = 1'b1;
                    end else begin
                        push    = 1'b1;
                        pc_d    = addr;
                        taken_d = 1'b1;
                    end
                end
                RET: begin
                    if (stack_empty) begin
                        udf_set = 1'b1;
                    end else begin
                        pop     = 1'b1;
                        pc_d    = tos;
                        taken_d = 1'b1;
                    end
                end
                JR: begin
                    pc_d    = r1[ADDR_W-1:0];
                    taken_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A new error in the clearing cycle wins over err_clr.
    assign ovf_d = ovf_set | (ovf_q & ~err_clr);
    assign udf_d = udf_set | (udf_q & ~err_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            taken_q <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            taken_q <= taken_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign pc      = pc_q;
    assign taken   = taken_q;
    assign ovf_err = ovf_q;
    assign udf_err = udf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (DEPTH=4) against a queue-based reference model.
module tb_pc_sequencer;

    localparam int unsigned AW  = 19;
    localparam int unsigned DW  = 19;
    localparam int unsigned DEP = 4;

    localparam logic [3:0] T_JMP = 4'd0, T_BEQ = 4'd1, T_BNE = 4'd2, T_CALL = 4'd3,
                           T_RET = 4'd4, T_BLT = 4'd5, T_JR = 4'd6, T_NOP = 4'd9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          op_valid = 1'b0;
    logic [3:0]    ctrl_op = '0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] r1 = '0, r2 = '0;
    logic          err_clr = 1'b0;
    logic [AW-1:0] pc;
    logic          taken;
    logic [2:0]    depth;
    logic          stack_full, stack_empty, ovf_err, udf_err;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_stack[$];
    logic          m_taken, m_ovf, m_udf;

    pc_sequencer #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .DEPTH    (DEP),
        .RESET_PC (19'd0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_valid    (op_valid),
        .ctrl_op     (ctrl_op),
        .addr        (addr),
        .r1          (r1),
        .r2          (r2),
        .err_clr     (err_clr),
        .pc          (pc),
        .taken       (taken),
        .depth       (depth),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .ovf_err     (ovf_err),
        .udf_err     (udf_err)
    );

    always #5 clk = ~clk;

    logic [26:0] obs;
    assign obs = {pc, taken, depth, stack_full, stack_empty, ovf_err, udf_err};

    function automatic logic [26:0] exp_vec();
        int n;
        n = m_stack.size();
        return {m_pc, m_taken, 3'(n), (n == int'(DEP)), (n == 0), m_ovf, m_udf};
    endfunction

    task automatic model_reset();
        m_pc    = '0;
        m_stack = {};
        m_taken = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    // Drives one cycle of stimulus, advances the model, returns at posedge+1.
    task automatic do_op(input logic v, input logic [3:0] op, input logic [AW-1:0] a,
                         input logic [DW-1:0] x, input logic [DW-1:0] y, input logic clr);
        logic [AW-1:0] nxt;
        op_valid = v; ctrl_op = op; addr = a; r1 = x; r2 = y; err_clr = clr;
        nxt = m_pc + 19'd1;
        if (clr) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end
        m_taken = 1'b0;
        if (v) begin
            case (op)
                T_JMP: begin nxt = a; m_taken = 1'b1; end
                T_BEQ: if (x == y) begin nxt = a; m_taken = 1'b1; end
                T_BNE: if (x != y) begin nxt = a; m_taken = 1'b1; end
                T_BLT: if ($signed(x) < $signed(y)) begin nxt = a; m_taken = 1'b1; end
                T_JR:  begin nxt = x[AW-1:0]; m_taken = 1'b1; end
                T_CALL: begin
                    if (m_stack.size() == int'(DEP)) m_ovf = 1'b1;
                    else begin m_stack.push_back(nxt); nxt = a; m_taken = 1'b1; end
                end
                T_RET: begin
                    if (m_stack.size() == 0) m_udf = 1'b1;
                    else begin nxt = m_stack.pop_back(); m_taken = 1'b1; end
                end
                default: ;
            endcase
            m_pc = nxt;
        end
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        err_clr  = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (obs !== exp_vec() || pc !== 19'd0 || stack_empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", obs, exp_vec());
        end
        for (int i = 1; i <= 3; i++) begin
            do_op(1'b1, T_NOP, '0, '0, '0, 1'b0);
            checks++;
            if (obs !== exp_vec() || pc !== 19'(i) || taken !== 1'b0 || stack_empty !== 1'b1) begin
                errors++;
                $display("FAIL nop_seq%0d got=%h exp=%h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_branches();
        do_op(1'b1, T_JMP, 19'd50, '0, '0, 1'b0);
        checks++;
        if (obs !== exp_vec() || pc !== 19'd50 || taken !== 1'b1) begin
            errors++; $display("FAIL jmp got pc=%0d taken=%b exp pc=50 taken=1", pc, taken);
        end
        do_op(1'b1, T_BEQ, 19'd80, 19'd10, 19'd10, 1'b0);
        checks++;
        if (obs !== exp_vec() || pc !== 19'd80 || taken !== 1'b1) begin
            errors++; $display("FAIL beq_taken got pc=%0d exp pc=80", pc);
        end
        do_op(1'b1, T_BNE, 19'd7, 19'd10, 19'd10, 1'b0);
        checks++;
        if (obs !== exp_vec() || pc !== 19'd81 || taken !== 1'b0) begin
            errors++; $display("FAIL bne_fall got pc=%0d taken=%b exp pc=81 taken=0", pc, taken);
        end
        do_op(1'b1, T_BLT, 19'd5, 19'h7FFFF, 19'd2, 1'b0);
        checks++;
        if (obs !== exp_vec() || pc !== 19'd5 || taken !== 1'b1) begin
            errors++; $display("FAIL blt_signed got pc=%0d exp pc=5", pc);
        end
        do_op(1'b1, T_JMP, 19'd6, '0, '0, 1'b0);
        checks++;
        if (obs !== exp_vec() || taken !== 1'b1) begin
            errors++; $display("FAIL jmp_to_next got taken=%b exp taken=1", taken);
        end
        do_op(1'b1, T_JR, '0, 19'd1234, '0, 1'b0);
        checks++;
        if (obs !== exp_vec() || pc !== 19'd1234) begin
            errors++; $display("FAIL jr got pc=%0d exp pc=1234", pc);
        end
    endtask

    task automatic test_nested_calls();
        do_op(1'b1, T_JMP, 19'd10, '0, '0, 1'b0);
        do_op(1'b1, T_CALL, 19'd100, '0, '0, 1'b0);
        do_op(1'b1, T_CALL, 19'd200, '0, '0, 1'b0);
        checks++;
        if (obs !== exp_vec() || pc !== 19'd200 || depth !== 3'd2) begin
            errors++; $display("FAIL nested_call got pc=%0d depth=%0d exp pc=200 depth=2", pc, depth);
        end
        do_op(1'b1, T_RET, '0, '0, '0, 1'b0);
        checks++;
        if (obs !== exp_vec() || pc !== 19'd101 || taken !== 1'b1) begin
            errors++; $display("FAIL ret_inner got pc=%0d exp pc=101", pc);
        end
        do_op(1'b1, T_RET, '0, '0, '0, 1'b0);
        checks++;
        if (obs !== exp_vec() || pc !== 19'd11 || depth !== 3'd0) begin
            errors++; $display("FAIL ret_outer got pc=%0d depth=%0d exp pc=11 depth=0", pc, depth);
        end
    endtask

    task automatic test_overflow_underflow();
        logic [AW-1:0] prev;
        for (int i = 1; i <= 4; i++) begin
            do_op(1'b1, T_CALL, 19'(i * 100), '0, '0, 1'b0);
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL call_fill%0d got=%h exp=%h", i, obs, exp_vec());
            end
        end
        prev = pc;
        do_op(1'b1, T_CALL, 19'd500, '0, '0, 1'b0);
        checks++;
        if (obs !== exp_vec() || ovf_err !== 1'b1 || pc !== prev + 19'd1 || depth !== 3'd4 || taken !== 1'b0) begin
            errors++; $display("FAIL overflow got=%h exp=%h", obs, exp_vec());
        end
        for (int i = 1; i <= 4; i++) begin
            do_op(1'b1, T_RET, '0, '0, '0, 1'b0);
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL ret_lifo%0d got=%h exp=%h", i, obs, exp_vec());
            end
        end
        do_op(1'b1, T_RET, '0, '0, '0, 1'b0);
        checks++;
        if (obs !== exp_vec() || udf_err !== 1'b1 || ovf_err !== 1'b1 || taken !== 1'b0) begin
            errors++; $display("FAIL underflow got=%h exp=%h", obs, exp_vec());
        end
        do_op(1'b1, T_NOP, '0, '0, '0, 1'b1);
        checks++;
        if (obs !== exp_vec() || udf_err !== 1'b0 || ovf_err !== 1'b0) begin
            errors++; $display("FAIL err_clr got ovf=%b udf=%b exp 0 0", ovf_err, udf_err);
        end
        do_op(1'b1, T_RET, '0, '0, '0, 1'b1);
        checks++;
        if (obs !== exp_vec() || udf_err !== 1'b1) begin
            errors++; $display("FAIL err_vs_clr got udf=%b exp udf=1", udf_err);
        end
        do_op(1'b1, T_NOP, '0, '0, '0, 1'b1);
    endtask

    task automatic test_wrap_and_hold();
        do_op(1'b1, T_JMP, 19'h7FFFF, '0, '0, 1'b0);
        do_op(1'b1, T_NOP, '0, '0, '0, 1'b0);
        checks++;
        if (obs !== exp_vec() || pc !== 19'd0 || taken !== 1'b0) begin
            errors++; $display("FAIL pc_wrap got pc=%0d exp pc=0", pc);
        end
        do_op(1'b1, T_JMP, 19'd77, '0, '0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            do_op(1'b0, T_JMP, 19'd300, '0, '0, 1'b0);
            checks++;
            if (obs !== exp_vec() || pc !== 19'd77 || taken !== 1'b0) begin
                errors++; $display("FAIL idle_hold%0d got pc=%0d taken=%b exp pc=77 taken=0", i, pc, taken);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_op(1'b1, T_JMP, 19'd40, '0, '0, 1'b0);
        do_op(1'b1, T_CALL, 19'd900, '0, '0, 1'b0);
        do_op(1'b1, T_RET, '0, '0, '0, 1'b0);
        checks++;
        if (obs !== exp_vec() || pc !== 19'd41 || depth !== 3'd0) begin
            errors++; $display("FAIL call_ret_b2b got pc=%0d exp pc=41", pc);
        end
    endtask

    task automatic test_reset_mid();
        do_op(1'b1, T_CALL, 19'd60, '0, '0, 1'b0);
        do_op(1'b1, T_CALL, 19'd70, '0, '0, 1'b0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== exp_vec() || pc !== 19'd0 || depth !== 3'd0) begin
            errors++; $display("FAIL reset_async got pc=%0d depth=%0d exp 0 0", pc, depth);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_op(1'b1, T_RET, '0, '0, '0, 1'b0);
        checks++;
        if (obs !== exp_vec() || udf_err !== 1'b1 || pc !== 19'd1) begin
            errors++; $display("FAIL ret_after_reset got=%h exp=%h", obs, exp_vec());
        end
    endtask

    task automatic test_random();
        logic [3:0]    op;
        logic [DW-1:0] x, y;
        logic          v, clr;
        for (int i = 0; i < 400; i++) begin
            op  = 4'($urandom_range(0, 9));
            x   = 19'($urandom);
            y   = ($urandom_range(0, 2) == 0) ? x : 19'($urandom);
            v   = ($urandom_range(0, 99) < 85);
            clr = ($urandom_range(0, 99) < 8);
            do_op(v, op, 19'($urandom), x, y, clr);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random%0d op=%0d v=%b got=%h exp=%h", i, op, v, obs, exp_vec());
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_branches();
        test_nested_calls();
        test_overflow_underflow();
        test_wrap_and_hold();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Clocked program-counter sequencer with a hardware return-address stack, for the 19-bit processor's fetch stage. It owns the PC register and evaluates one control operation per accepted cycle: jump, conditional branch, call or return. Address width, operand width and stack depth are parameters. It detects stack overflow and underflow, and exposes stack occupancy so the pipeline can trap or stall.

## Interface
Parameters:
- `ADDR_W`, 19, width of PC, jump target and stack entries
- `DATA_W`, 19, width of compared operands `r1`/`r2`
- `DEPTH`, 256, return-stack entries; power of two, ≥ 2
- `RESET_PC`, 0, PC value loaded at reset

Ports (clock and reset are decided: one clock; reset asynchronous, active-low):
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `op_valid` in 1: `ctrl_op` is valid this cycle; when low, all state holds
- `ctrl_op` in 4: operation code
- `addr` in ADDR_W: branch/jump/call target
- `r1`, `r2` in DATA_W: compare operands; `r1[ADDR_W-1:0]` is also the JR target
- `err_clr` in 1: clears the sticky error flags
- `pc` out ADDR_W: current program counter (registered)
- `taken` out 1: registered; 1 for one cycle when the last accepted op redirected away from pc+1
- `depth` out $clog2(DEPTH)+1: stack occupancy
- `stack_full`, `stack_empty` out 1: combinational from `depth`
- `ovf_err`, `udf_err` out 1: sticky overflow / underflow flags

## Operation
- Encodings:
  - JMP=0: target = `addr`
  - BEQ=1: target = `addr` if `r1==r2`, else pc+1
  - BNE=2: target = `addr` if `r1!=r2`, else pc+1
  - CALL=3: push pc+1, target = `addr`
  - RET=4: pop, target = popped value
  - BLT=5: target = `addr` if `$signed(r1)<$signed(r2)`, else pc+1
  - JR=6: target = `r1[ADDR_W-1:0]`
  - All other codes: NOP, pc+1
- pc+1 wraps modulo 2^ADDR_W; `RESET_PC`+… likewise.
- Stack is a LIFO. A push writes entry[`depth`] and increments `depth`; a pop reads entry[`depth`-1] and decrements `depth`.
- CALL when `depth==DEPTH`:
  - no push, no redirect, pc ← pc+1
  - `ovf_err` ← 1
  - `taken` = 0
- RET when `depth==0`:
  - no pop, pc ← pc+1
  - `udf_err` ← 1
  - `taken` = 0
- `taken` = 1 only when the next pc ≠ pc+1 because of a redirect. A JMP to pc+1 still reports `taken`=1.
- `err_clr` clears both flags on the next edge. If an error occurs in the same cycle as `err_clr`, the new error wins: the flag is set.
- `op_valid`=0: pc, `depth`, stack and flags hold; `taken` ← 0.

## Timing
- Reset (asynchronous assert, synchronous release):
  - pc = `RESET_PC`
  - `depth` = 0, so `stack_empty`=1 and `stack_full`=0
  - `taken`, `ovf_err`, `udf_err` = 0
  - Stack contents are not cleared.
- Latency is 1 cycle: an op accepted at edge N makes `pc`, `taken`, `depth` and the flags visible after edge N.
- Back-to-back ops are supported every cycle, including CALL followed by RET: the RET returns the just-pushed value.
- Reset mid-sequence discards stack occupancy. A RET after reset underflows.

## Structure
- Shared package `cu_pkg`: the op-code localparams (JMP…JR, `OP_W`=4) and a function computing the branch condition.
- One sub-module, `ret_addr_stack`:
  - parameters `ADDR_W`, `DEPTH`
  - ports: `push`, `pop`, `din`, `dout` (combinational top-of-stack), `depth`, `full`, `empty`
  - guards against push-on-full and pop-on-empty internally
- The top level holds the pc register, target mux, `taken` and error flags.

## Test plan
- Reset, then NOP ×3 -> pc 0,1,2,3; `taken`=0; `stack_empty`=1.
- pc=0, JMP `addr`=50 -> pc=50, `taken`=1. Then BEQ with r1=r2=10, `addr`=80 -> pc=80. Then BNE with r1=r2 -> pc=81, `taken`=0. Then BLT with r1=-1, r2=2, `addr`=5 -> pc=5.
- Nested calls: at pc=10, CALL 100; at 100, CALL 200 -> `depth`=2. RET -> pc=101. RET -> pc=11, `depth`=0.
- With `DEPTH`=4: 5 CALLs -> 5th gives `ovf_err`=1, pc=prev+1, `depth`=4. Then RET ×4 return in LIFO order. 5th RET -> `udf_err`=1. Then `err_clr` clears both flags.
- pc=2^19-1, NOP -> pc=0. `op_valid`=0 for 3 cycles -> pc holds, `taken`=0.
- After 2 CALLs, assert `rst_n`=0 mid-cycle -> pc=`RESET_PC` immediately, `depth`=0. After release, RET -> `udf_err`=1.
